// File: rtl/alu_pkg.sv
// Shared ALU/writeback types: status-flag bit positions, writeback FSM states, entry sideband.
package alu_pkg;

  localparam int FLAG_Z  = 0;
  localparam int FLAG_C  = 1;
  localparam int FLAG_GT = 2;
  localparam int FLAG_EQ = 3;

  // Register-address width of the sideband; the stage's RADDR default tracks it.
  localparam int WB_RD_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } e_wb_state;

  typedef struct packed {
    logic [WB_RD_W-1:0] rd;
    logic               we;
  } wb_meta_t;

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry skid buffer (main, then skid) with valid/ready on both sides; 1-cycle latency.
// in_ready is decoded from the state register only, so it never depends on out_ready.
module wb_skid_buf
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  e_wb_state    state, state_nxt;
  logic [W-1:0] main_q, skid_q;
  logic         accept, pop;
  logic         load_main_in, load_main_skid, load_skid;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_in)
        main_q <= in_data;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_data;
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: skid-buffered result toward the register file plus the {EQ,GT,C,Z} status register.
// Define ALU_WB_CARRY_BYPASS_EN to forward the accepting entry's carry to cin combinationally.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int WORD  = 8,
  parameter int RADDR = WB_RD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD-1:0]  in_result,
  input  logic             in_cout,
  input  logic             in_zero,
  input  logic             in_gt,
  input  logic             in_equal,
  input  logic [RADDR-1:0] in_rd,
  input  logic             in_we,
  input  logic             in_setf,
  input  logic             flags_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_data,
  output logic [RADDR-1:0] out_rd,
  output logic             out_we,
  output logic [3:0]       flags,
  output logic             cin
);

  localparam int PW = WORD + $bits(wb_meta_t);

  wb_meta_t        meta_in, meta_out;
  logic [PW-1:0]   buf_in, buf_out;
  logic [WORD-1:0] data_out;
  logic [3:0]      flags_q;
  logic            accept;

  assign meta_in.rd = WB_RD_W'(in_rd);
  assign meta_in.we = in_we;
  assign buf_in     = {in_result, meta_in};

  wb_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (buf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign {data_out, meta_out} = buf_out;
  assign out_data = data_out;
  assign out_rd   = RADDR'(meta_out.rd);
  assign out_we   = meta_out.we;

  assign accept = in_valid && in_ready;

  // Flags follow the accepted instruction, not the popped one; setf beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (accept && in_setf) begin
      flags_q[FLAG_Z]  <= in_zero;
      flags_q[FLAG_C]  <= in_cout;
      flags_q[FLAG_GT] <= in_gt;
      flags_q[FLAG_EQ] <= in_equal;
    end else if (flags_clr) begin
      flags_q <= '0;
    end
  end

  assign flags = flags_q;

`ifdef ALU_WB_CARRY_BYPASS_EN
  assign cin = (accept && in_setf) ? in_cout : flags_q[FLAG_C];
`else
  assign cin = flags_q[FLAG_C];
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage: reset, streaming, backpressure, flags, carry, reset mid-stream, ordering.
module tb_alu_wb_stage;

  localparam int WORD  = 8;
  localparam int RADDR = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WORD-1:0]  in_result;
  logic             in_cout;
  logic             in_zero;
  logic             in_gt;
  logic             in_equal;
  logic [RADDR-1:0] in_rd;
  logic             in_we;
  logic             in_setf;
  logic             flags_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WORD-1:0]  out_data;
  logic [RADDR-1:0] out_rd;
  logic             out_we;
  logic [3:0]       flags;
  logic             cin;

  int n_chk  = 0;
  int n_fail = 0;

  alu_wb_stage #(.WORD(WORD), .RADDR(RADDR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_cout   (in_cout),
    .in_zero   (in_zero),
    .in_gt     (in_gt),
    .in_equal  (in_equal),
    .in_rd     (in_rd),
    .in_we     (in_we),
    .in_setf   (in_setf),
    .flags_clr (flags_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_we    (out_we),
    .flags     (flags),
    .cin       (cin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WORD-1:0] r, input logic [RADDR-1:0] rd,
                       input logic we, input logic co, input logic z, input logic gt,
                       input logic eq, input logic sf);
    in_valid  = v;
    in_result = r;
    in_rd     = rd;
    in_we     = we;
    in_cout   = co;
    in_zero   = z;
    in_gt     = gt;
    in_equal  = eq;
    in_setf   = sf;
  endtask

  logic [WORD+RADDR:0] sb_q[$];
  logic [WORD+RADDR:0] sb_exp;
  int    sent, rcvd, cyc;
  logic  acc, acc_prev, pop;

  initial begin
    rst_n     = 1'b1;
    out_ready = 1'b0;
    flags_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_cin", 32'(cin), 0);
    chk("rst_out_data", 32'(out_data), 0);
    rst_n = 1'b1;

    // Streaming at full throughput
    tick();
    out_ready = 1'b1;
    drive(1, 220, 1, 1, 0, 0, 0, 0, 0);
    tick();
    chk("stream_data0", 32'(out_data), 220);
    chk("stream_rd0", 32'(out_rd), 1);
    chk("stream_rdy0", 32'(in_ready), 1);
    drive(1, 20, 2, 0, 0, 0, 0, 0, 0);
    tick();
    chk("stream_data1", 32'(out_data), 20);
    chk("stream_we1", 32'(out_we), 0);
    chk("stream_rdy1", 32'(in_ready), 1);
    drive(1, 96, 3, 1, 0, 0, 0, 0, 0);
    tick();
    chk("stream_data2", 32'(out_data), 96);
    chk("stream_vld2", 32'(out_valid), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("stream_drain", 32'(out_valid), 0);

    // Backpressure into FULL and drain
    out_ready = 1'b0;
    drive(1, 5, 1, 1, 0, 0, 0, 0, 0);
    tick();
    chk("bp_data_a", 32'(out_data), 5);
    chk("bp_rdy_a", 32'(in_ready), 1);
    drive(1, 40, 2, 1, 0, 0, 0, 0, 0);
    tick();
    chk("bp_full_rdy", 32'(in_ready), 0);
    chk("bp_full_data", 32'(out_data), 5);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("bp_hold_data", 32'(out_data), 5);
    chk("bp_hold_rdy", 32'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    chk("bp_pop_data", 32'(out_data), 40);
    chk("bp_pop_rd", 32'(out_rd), 2);
    chk("bp_pop_rdy", 32'(in_ready), 1);
    tick();
    chk("bp_empty", 32'(out_valid), 0);

    // Flags and carry feedback
    drive(1, 0, 0, 1, 1, 1, 0, 0, 1);
    #1;
`ifdef ALU_WB_CARRY_BYPASS_EN
    chk("cin_same_cycle", 32'(cin), 1);
`else
    chk("cin_same_cycle", 32'(cin), 0);
`endif
    tick();
    chk("flags_set", 32'(flags), 4'b0011);
    chk("cin_next_cycle", 32'(cin), 1);
    drive(1, 7, 1, 1, 0, 0, 1, 0, 0);
    tick();
    chk("flags_nosetf", 32'(flags), 4'b0011);
    drive(1, 9, 1, 1, 0, 0, 1, 0, 1);
    flags_clr = 1'b1;
    tick();
    chk("flags_setf_wins", 32'(flags), 4'b0100);
    chk("cin_cleared", 32'(cin), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("flags_clr_only", 32'(flags), 0);
    flags_clr = 1'b0;
    tick();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    drive(1, 11, 1, 1, 1, 0, 1, 1, 1);
    tick();
    drive(1, 12, 2, 1, 1, 0, 1, 1, 1);
    tick();
    chk("pre_rst_full", 32'(in_ready), 0);
    chk("pre_rst_flags", 32'(flags), 4'b1110);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 0);
    chk("mid_rst_rdy", 32'(in_ready), 1);
    chk("mid_rst_flags", 32'(flags), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_vld", 32'(out_valid), 0);

    // Ordering under random backpressure
    sent = 0;
    rcvd = 0;
    cyc = 0;
    acc_prev = 1'b0;
    while ((sent < 200 || sb_q.size() > 0) && cyc < 5000) begin
      if (!in_valid || acc_prev) begin
        if (sent < 200 && ($urandom % 4) != 0)
          drive(1, WORD'($urandom), RADDR'($urandom), 1'($urandom), 0, 0, 0, 0, 0);
        else
          in_valid = 1'b0;
      end
      out_ready = 1'($urandom);
      #1;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          sb_exp = sb_q.pop_front();
          chk("sb_entry", 32'({out_data, out_rd, out_we}), 32'(sb_exp));
          rcvd++;
        end
      end
      if (acc) begin
        sb_q.push_back({in_result, in_rd, in_we});
        sent++;
      end
      acc_prev = acc;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("sb_sent", 32'(sent), 200);
    chk("sb_rcvd", 32'(rcvd), 200);
    chk("sb_left", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
